watch_fnd_ctrl: RTL and testbench

Downstream display stage for `watch_top`. Consumes the binary `o_sec`/`o_min`/`o_hour` outputs and converts each field to two BCD digits with a sequential double-dabble FSM. Drives a 6-digit, common-select, multiplexed 7-segment (FND) display by time-scanning. Both outputs are active-low.

---
 rtl/watch_fnd_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_watch_fnd_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/watch_fnd_ctrl.sv
// watch_fnd_ctrl: binary sec/min/hour -> BCD (sequential double-dabble) -> 6-digit multiplexed active-low FND; optional blink via WATCH_FND_BLINK_EN.
// Latency: 20 cycles from input change to new segments; no backpressure, inputs are resampled only while IDLE (o_busy low).
module watch_fnd_ctrl #(
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5,
  parameter int P_SCAN_CYC  = 1000,
  parameter int P_BLINK_RND = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run_en,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  output logic [5:0]            o_fnd_com,
  output logic [7:0]            o_fnd_seg,
  output logic                  o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam int             SCW       = $clog2(P_SCAN_CYC);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(P_SCAN_CYC - 1);

  logic [5:0]      sec_w, min_w, hour_w;
  state_t          st_q;
  logic [5:0]      sec_q, min_q, hour_q;
  logic [17:0]     sh_q;
  logic [4:0]      it_q;
  bcd2_t           acc_q, acc_d;
  logic [7:0]      acc_adj;
  bcd2_t           sec_bcd_q, min_bcd_q;
  logic [5:0][3:0] disp_q;
  logic            busy_q;
  logic            in_diff;

  logic [SCW-1:0]  cnt_q, cnt_d;
  logic [2:0]      dig_q, dig_d;
  logic            scan_wrap;
  logic            com_off;
  logic [5:0]      com_q;
  logic [7:0]      seg_q;
  logic            dp_n;

  assign sec_w  = 6'(i_sec);
  assign min_w  = 6'(i_min);
  assign hour_w = 6'(i_hour);

  assign in_diff = {hour_w, min_w, sec_w} != {hour_q, min_q, sec_q};

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // One double-dabble step: add-3 on both nibbles, then shift in the next MSB.
  always_comb begin
    acc_adj = {add3(acc_q.tens), add3(acc_q.ones)};
    acc_d   = {acc_adj[6:0], sh_q[17]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= S_IDLE;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      sh_q      <= '0;
      it_q      <= '0;
      acc_q     <= '0;
      sec_bcd_q <= '0;
      min_bcd_q <= '0;
      disp_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (in_diff) begin
            sec_q  <= sec_w;
            min_q  <= min_w;
            hour_q <= hour_w;
            sh_q   <= {sec_w, min_w, hour_w};
            it_q   <= '0;
            acc_q  <= '0;
            busy_q <= 1'b1;
            st_q   <= S_CONV;
          end
        end
        S_CONV: begin
          sh_q  <= {sh_q[16:0], 1'b0};
          it_q  <= it_q + 5'd1;
          acc_q <= acc_d;
          // Each field's last bit parks its BCD pair and restarts the accumulator.
          case (it_q)
            5'd5: begin
              sec_bcd_q <= acc_d;
              acc_q     <= '0;
            end
            5'd11: begin
              min_bcd_q <= acc_d;
              acc_q     <= '0;
            end
            5'd17:   st_q <= S_DONE;
            default: ;
          endcase
        end
        S_DONE: begin
          disp_q <= {acc_q, min_bcd_q, sec_bcd_q};
          busy_q <= 1'b0;
          st_q   <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign scan_wrap = (cnt_q == SCAN_LAST);

  always_comb begin
    cnt_d = scan_wrap ? '0 : cnt_q + SCW'(1);
    dig_d = dig_q;
    if (scan_wrap) begin
      dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      dig_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
    end
  end

`ifdef WATCH_FND_BLINK_EN
  localparam int RNW = $clog2(P_BLINK_RND) + 1;

  logic [RNW-1:0] rnd_q;
  logic           blank_q;
  logic           round_wrap;

  assign round_wrap = scan_wrap && (dig_q == 3'd5);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd_q   <= '0;
      blank_q <= 1'b0;
    end else if (round_wrap) begin
      if (rnd_q == RNW'(P_BLINK_RND - 1)) begin
        rnd_q   <= '0;
        blank_q <= ~blank_q;
      end else begin
        rnd_q <= rnd_q + RNW'(1);
      end
    end
  end

  // A running watch is never blanked; the phase keeps counting regardless.
  assign com_off = blank_q & ~i_run_en;
`else
  logic unused_blink;

  assign unused_blink = i_run_en & (P_BLINK_RND > 0);
  assign com_off      = 1'b0;
`endif

  assign dp_n = ~((dig_q == 3'd2) | (dig_q == 3'd4));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      com_q <= 6'h3F;
      seg_q <= 8'hFF;
    end else begin
      com_q <= com_off ? 6'h3F : ~(6'd1 << dig_q);
      seg_q <= {dp_n, seg7(disp_q[dig_q])};
    end
  end

  assign o_fnd_com = com_q;
  assign o_fnd_seg = seg_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_watch_fnd_ctrl.sv
// Bench for watch_fnd_ctrl: table of conversions read back digit by digit, plus hand
// sequences for scan order, change-while-busy, reset mid-conversion and blinking.
module tb_watch_fnd_ctrl;

`ifdef WATCH_FND_BLINK_EN
  localparam int SCAN = 2;
`else
  localparam int SCAN = 4;
`endif
  localparam int BRND      = 2;
  localparam int BLINK_WIN = 6 * SCAN * BRND;
  localparam int NV        = 6;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       i_run_en = 1'b1;
  logic [5:0] i_sec    = '0;
  logic [5:0] i_min    = '0;
  logic [4:0] i_hour   = '0;
  logic [5:0] o_fnd_com;
  logic [7:0] o_fnd_seg;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]      hr;
    logic [5:0]      mn;
    logic [5:0]      sc;
    logic [5:0][7:0] seg;
  } vec_t;

  vec_t vecs [NV];

  watch_fnd_ctrl #(
    .P_SEC_BIT  (6),
    .P_MIN_BIT  (6),
    .P_HOUR_BIT (5),
    .P_SCAN_CYC (SCAN),
    .P_BLINK_RND(BRND)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_run_en (i_run_en),
    .i_sec    (i_sec),
    .i_min    (i_min),
    .i_hour   (i_hour),
    .o_fnd_com(o_fnd_com),
    .o_fnd_seg(o_fnd_seg),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts consecutive negedges with busy high, starting at the current negedge.
  task automatic measure_busy(output int len);
    len = 0;
    while (o_busy && len < 60) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic read_digit(input int d, output logic [7:0] seg);
    logic [5:0] want;
    bit         found;
    want  = ~(6'd1 << d);
    found = 1'b0;
    seg   = 8'hxx;
    for (int k = 0; k < 6 * SCAN + 4 && !found; k++) begin
      if (o_fnd_com === want) begin
        seg   = o_fnd_seg;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int         len;
    int         gap;
    int         bad;
    logic [7:0] seg;
    logic [5:0] exp_com;

    vecs[0] = '{hr: 5'd13, mn: 6'd7,  sc: 6'd45, seg: {8'hF9, 8'h30, 8'hC0, 8'h78, 8'h99, 8'h92}};
    vecs[1] = '{hr: 5'd23, mn: 6'd59, sc: 6'd59, seg: {8'hA4, 8'h30, 8'h92, 8'h10, 8'h92, 8'h90}};
    vecs[2] = '{hr: 5'd9,  mn: 6'd10, sc: 6'd8,  seg: {8'hC0, 8'h10, 8'hF9, 8'h40, 8'hC0, 8'h80}};
    vecs[3] = '{hr: 5'd12, mn: 6'd34, sc: 6'd56, seg: {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}};
    vecs[4] = '{hr: 5'd31, mn: 6'd0,  sc: 6'd63, seg: {8'hB0, 8'h79, 8'hC0, 8'h40, 8'h82, 8'hB0}};
    vecs[5] = '{hr: 5'd0,  mn: 6'd0,  sc: 6'd0,  seg: {8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'hC0}};

    // Reset state and scan order
    repeat (3) @(negedge clk);
    check("rst_com", o_fnd_com, 6'h3F);
    check("rst_seg", o_fnd_seg, 8'hFF);
    check("rst_busy", o_busy, 1'b0);
    reset = 1'b0;
    for (int n = 1; n <= 7 * SCAN; n++) begin
      @(negedge clk);
      exp_com = ~(6'd1 << (((n - 1) / SCAN) % 6));
      check($sformatf("scan_com_%0d", n), o_fnd_com, exp_com);
      if (n == 1) check("first_seg", o_fnd_seg, 8'hC0);
    end
    check("idle_busy", o_busy, 1'b0);

    // Conversion vectors
    for (int i = 0; i < NV; i++) begin
      i_hour = vecs[i].hr;
      i_min  = vecs[i].mn;
      i_sec  = vecs[i].sc;
      @(negedge clk);
      measure_busy(len);
      check($sformatf("v%0d_busy_len", i), len, 19);
      @(negedge clk);
      for (int d = 0; d < 6; d++) begin
        read_digit(d, seg);
        check($sformatf("v%0d_dig%0d", i, d), seg, vecs[i].seg[d]);
      end
    end

    // Change while busy: second value is held off until the first conversion commits
    i_sec = 6'd10;
    @(negedge clk);
    len = 0;
    while (o_busy && len < 60) begin
      len++;
      if (len == 5) i_sec = 6'd11;
      @(negedge clk);
    end
    check("chg_first_len", len, 19);
    check("chg_first_disp", {dut.disp_q[1], dut.disp_q[0]}, 8'h10);
    gap = 0;
    while (!o_busy && gap < 60) begin
      gap++;
      @(negedge clk);
    end
    check("chg_gap", gap, 1);
    measure_busy(len);
    check("chg_second_len", len, 19);
    @(negedge clk);
    read_digit(0, seg);
    check("chg_sec_ones", seg, 8'hF9);
    read_digit(1, seg);
    check("chg_sec_tens", seg, 8'hF9);

    // Reset asserted mid-conversion, then reconversion after release
    i_hour = 5'd31;
    i_min  = 6'd0;
    i_sec  = 6'd63;
    repeat (6) @(negedge clk);
    check("mid_busy", o_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_com", o_fnd_com, 6'h3F);
    check("mid_rst_seg", o_fnd_seg, 8'hFF);
    check("mid_rst_busy", o_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_com", o_fnd_com, 6'h3E);
    check("rel_seg", o_fnd_seg, 8'hC0);
    measure_busy(len);
    check("rel_busy_len", len, 19);
    @(negedge clk);
    for (int d = 0; d < 6; d++) begin
      read_digit(d, seg);
      check($sformatf("reconv_dig%0d", d), seg, vecs[4].seg[d]);
    end

    // Blink phase with the watch stopped, then running
    i_run_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int n = 1; n <= 4 * BLINK_WIN; n++) begin
      @(negedge clk);
      exp_com = ~(6'd1 << (((n - 1) / SCAN) % 6));
`ifdef WATCH_FND_BLINK_EN
      if ((((n - 1) / BLINK_WIN) % 2) == 1) exp_com = 6'h3F;
`endif
      if (o_fnd_com !== exp_com) bad++;
    end
    check("stopped_com_bad_cycles", bad, 0);
    i_run_en = 1'b1;
    bad = 0;
    for (int n = 4 * BLINK_WIN + 1; n <= 8 * BLINK_WIN; n++) begin
      @(negedge clk);
      exp_com = ~(6'd1 << (((n - 1) / SCAN) % 6));
      if (o_fnd_com !== exp_com) bad++;
    end
    check("running_com_bad_cycles", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
